bayer_demosaic_stream: RTL and testbench

//  Streaming Bayer-to-RGB converter for the camera pipeline, between the sensor capture block and the RGB consumers (grey/threshold, SDRAM writer).

---
 rtl/bayer_demosaic_stream_if.sv | 36 +++
 rtl/bayer_demosaic_stream.sv | 201 ++++++++++++++++++++
 tb/tb_bayer_demosaic_stream.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bayer_demosaic_stream_if.sv
// Stream bundle for the Bayer demosaic block: frame configuration, RAW pixel input and RGB result.
// The slave modport is the converter's view. The master modport is the capture/driver side.
interface bayer_demosaic_stream_if #(
  parameter int N = 8
);
  logic [11:0]  width;
  logic [1:0]   pattern;
  logic         decimate;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic [11:0]  in_x;
  logic [11:0]  in_y;
  logic         in_done;
  logic [N-1:0] out_red;
  logic [N-1:0] out_green;
  logic [N-1:0] out_blue;
  logic [11:0]  out_x;
  logic [11:0]  out_y;
  logic [1:0]   out_phase;
  logic         out_valid;
  logic         out_done;
  logic [23:0]  out_count;
  logic         out_error;

  modport master (
    output width, pattern, decimate, in_valid, in_data, in_x, in_y, in_done,
    input  out_red, out_green, out_blue, out_x, out_y, out_phase,
           out_valid, out_done, out_count, out_error
  );

  modport slave (
    input  width, pattern, decimate, in_valid, in_data, in_x, in_y, in_done,
    output out_red, out_green, out_blue, out_x, out_y, out_phase,
           out_valid, out_done, out_count, out_error
  );
endinterface

// File: rtl/bayer_demosaic_stream.sv
// Streaming Bayer-to-RGB converter. A one-line RAM and left-neighbour registers form a 2x2 window
// around each accepted RAW pixel. Output is full resolution or 2x2 decimated, with a fixed 2-cycle latency.
module bayer_demosaic_stream #(
  parameter int N         = 8,
  parameter int MAX_WIDTH = 2048,
  parameter bit ROUND     = 1'b0
) (
  input logic                   clock,
  input logic                   reset,
  bayer_demosaic_stream_if.slave bus
);

  localparam int         AW  = $clog2(MAX_WIDTH);
  localparam logic [N:0] RND = {{N{1'b0}}, ROUND};

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [11:0] width_q;
  logic [1:0]  pattern_q;
  logic        decimate_q;

  logic        frame_start;
  logic        live;
  logic        in_bounds;
  logic        accept;
  logic        err_set;
  logic        done_evt;
  logic        emit;
  logic [11:0] width_eff;
  logic [1:0]  pattern_eff;
  logic        decimate_eff;
  logic [1:0]  q_in;
  logic [11:0] ox_in;
  logic [11:0] oy_in;

  // Control and stage-0 decode. Pixel (0,0) starts a frame from any state, and also restarts a running one.
  // NOTE: every signal driven here gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    width_eff    = width_q;
    pattern_eff  = pattern_q;
    decimate_eff = decimate_q;
    frame_start  = bus.in_valid && (bus.in_x == 12'd0) && (bus.in_y == 12'd0);
    if (frame_start) begin
      width_eff    = bus.width;
      pattern_eff  = bus.pattern;
      decimate_eff = bus.decimate;
    end
    live      = frame_start || (state_q == ACTIVE);
    in_bounds = (bus.in_x < width_eff) && ({1'b0, bus.in_x} < 13'(MAX_WIDTH));
    accept    = bus.in_valid && live && in_bounds;
    err_set   = bus.in_valid && live && !in_bounds;
    done_evt  = (state_q == ACTIVE) && bus.in_done;
    emit      = accept && (decimate_eff ? (bus.in_x[0] && bus.in_y[0])
                                        : ((bus.in_x != 12'd0) && (bus.in_y != 12'd0)));
    q_in      = {bus.in_y[0] ^ pattern_eff[1], bus.in_x[0] ^ pattern_eff[0]};
    ox_in     = decimate_eff ? {1'b0, bus.in_x[11:1]} : (bus.in_x - 12'd1);
    oy_in     = decimate_eff ? {1'b0, bus.in_y[11:1]} : (bus.in_y - 12'd1);

    case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (bus.in_done) state_d = DONE;
      DONE:    state_d = frame_start ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      width_q    <= '0;
      pattern_q  <= '0;
      decimate_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        width_q    <= bus.width;
        pattern_q  <= bus.pattern;
        decimate_q <= bus.decimate;
      end
    end
  end

  // Line RAM holds row y-1. Each accepted pixel reads its column and then overwrites it.
  logic [N-1:0] line_ram [MAX_WIDTH];
  logic [N-1:0] ram_q;
  logic [N-1:0] left_r;
  logic [N-1:0] d00_r;
  logic [N-1:0] d10_r;
  logic [N-1:0] d11_r;
  logic [AW-1:0] addr;

  assign addr = bus.in_x[AW-1:0];

  // NOTE: the line RAM and the window data have no reset. They are only read once the emit
  // conditions guarantee that the row above and the left column have been written this frame.
  always_ff @(posedge clock) begin
    if (accept) begin
      ram_q          <= line_ram[addr];
      line_ram[addr] <= bus.in_data;
      d00_r          <= ram_q;
      d10_r          <= left_r;
      d11_r          <= bus.in_data;
      left_r         <= bus.in_data;
    end
  end

  logic        s1_emit;
  logic        s1_done;
  logic [1:0]  s1_q;
  logic [11:0] s1_x;
  logic [11:0] s1_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_emit <= 1'b0;
      s1_done <= 1'b0;
      s1_q    <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      s1_emit <= emit;
      s1_done <= done_evt;
      if (emit) begin
        s1_q <= q_in;
        s1_x <= ox_in;
        s1_y <= oy_in;
      end
    end
  end

  function automatic logic [N-1:0] avg(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] sum;
    sum = {1'b0, a} + {1'b0, b} + RND;
    return sum[N:1];
  endfunction

  logic [N-1:0] red_c, green_c, blue_c;

  // d01 is the fresh RAM read of the current column, and d00 is the read for the column to the left.
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    case (s1_q)
      2'b00: begin red_c = d11_r; blue_c = d00_r; green_c = avg(ram_q, d10_r); end
      2'b01: begin red_c = d10_r; blue_c = ram_q; green_c = avg(d00_r, d11_r); end
      2'b10: begin red_c = ram_q; blue_c = d10_r; green_c = avg(d00_r, d11_r); end
      default: begin red_c = d00_r; blue_c = d11_r; green_c = avg(ram_q, d10_r); end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_red   <= '0;
      bus.out_green <= '0;
      bus.out_blue  <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_phase <= '0;
      bus.out_valid <= 1'b0;
      bus.out_done  <= 1'b0;
      bus.out_count <= '0;
      bus.out_error <= 1'b0;
    end else begin
      bus.out_valid <= s1_emit;
      bus.out_done  <= s1_done;
      if (s1_emit) begin
        bus.out_red   <= red_c;
        bus.out_green <= green_c;
        bus.out_blue  <= blue_c;
        bus.out_x     <= s1_x;
        bus.out_y     <= s1_y;
        bus.out_phase <= s1_q;
      end else begin
        bus.out_red   <= '0;
        bus.out_green <= '0;
        bus.out_blue  <= '0;
      end
      // A frame start clears the counter even when the previous frame's tail is still in flight.
      if (frame_start) begin
        bus.out_count <= '0;
      end else if (s1_emit && (bus.out_count != 24'hFF_FFFF)) begin
        bus.out_count <= bus.out_count + 24'd1;
      end
      if (frame_start) begin
        bus.out_error <= err_set;
      end else if (err_set) begin
        bus.out_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Directed bench for bayer_demosaic_stream. A truncating (ROUND=0) instance and a rounding (ROUND=1)
// instance see the same stimulus, and their outputs are compared against hand-computed tables.
module tb_bayer_demosaic_stream;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  bayer_demosaic_stream_if #(.N(8)) bus0 ();
  bayer_demosaic_stream_if #(.N(8)) bus1 ();

  assign bus1.width    = bus0.width;
  assign bus1.pattern  = bus0.pattern;
  assign bus1.decimate = bus0.decimate;
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.in_data  = bus0.in_data;
  assign bus1.in_x     = bus0.in_x;
  assign bus1.in_y     = bus0.in_y;
  assign bus1.in_done  = bus0.in_done;

  bayer_demosaic_stream #(.N(8), .MAX_WIDTH(2048), .ROUND(1'b0)) dut_r0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  bayer_demosaic_stream #(.N(8), .MAX_WIDTH(2048), .ROUND(1'b1)) dut_r1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  ph;
    logic [31:0] cyc;
  } out_rec_t;

  out_rec_t q0[$];
  out_rec_t q1[$];
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // RGGB 4x4 ramp (data = 4*y + x), full resolution, in raster order.
  int exp_r [9] = '{0, 2, 2, 8, 10, 10, 8, 10, 10};
  int exp_g [9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
  int exp_b [9] = '{5, 5, 7, 5, 5, 7, 13, 13, 15};
  int exp_x [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_y [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int dec_i [4] = '{0, 2, 6, 8};
  int dec_x [4] = '{0, 1, 0, 1};
  int dec_y [4] = '{0, 0, 1, 1};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus0.out_valid)
      q0.push_back({bus0.out_red, bus0.out_green, bus0.out_blue, bus0.out_x, bus0.out_y,
                    bus0.out_phase, 32'(cyc)});
    if (bus1.out_valid)
      q1.push_back({bus1.out_red, bus1.out_green, bus1.out_blue, bus1.out_x, bus1.out_y,
                    bus1.out_phase, 32'(cyc)});
    if (bus0.out_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic out_rec_t pop0();
    if (q0.size() > 0) return q0.pop_front();
    return '0;
  endfunction

  function automatic out_rec_t pop1();
    if (q1.size() > 0) return q1.pop_front();
    return '0;
  endfunction

  task automatic px(input int x, input int y, input int d, input bit done);
    @(negedge clock);
    bus0.in_valid = 1'b1;
    bus0.in_x     = 12'(x);
    bus0.in_y     = 12'(y);
    bus0.in_data  = 8'(d);
    bus0.in_done  = done;
    last_cyc      = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus0.in_valid = 1'b0;
      bus0.in_done  = 1'b0;
    end
  endtask

  task automatic done_pulse();
    @(negedge clock);
    bus0.in_valid = 1'b0;
    bus0.in_done  = 1'b1;
    @(negedge clock);
    bus0.in_done  = 1'b0;
  endtask

  task automatic ramp(input int rows, input bit done_last);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < 4; x++)
        px(x, y, 4 * y + x, done_last && (y == rows - 1) && (x == 3));
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  out_rec_t rec;
  int base_done;

  initial begin
    bus0.width    = 12'd4;
    bus0.pattern  = 2'b00;
    bus0.decimate = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    bus0.in_x     = '0;
    bus0.in_y     = '0;
    bus0.in_done  = 1'b0;

    // Reset state
    idle(3);
    check("rst_valid_done", {bus0.out_valid, bus0.out_done}, 2'b00);
    check("rst_count", bus0.out_count, 0);
    check("rst_error", bus0.out_error, 0);
    check("rst_rgb", {bus0.out_red, bus0.out_green, bus0.out_blue}, 0);
    check("rst_xy_phase", {bus0.out_x, bus0.out_y, bus0.out_phase}, 0);
    reset = 1'b0;
    idle(2);

    // RGGB full resolution. The last pixel coincides with in_done.
    q0.delete();
    ramp(4, 1'b1);
    idle(4);
    check("rggb_n_out", q0.size(), 9);
    for (int i = 0; i < 9; i++) begin
      rec = pop0();
      check($sformatf("rggb_rgb%0d", i), {rec.r, rec.g, rec.b},
            {8'(exp_r[i]), 8'(exp_g[i]), 8'(exp_b[i])});
      check($sformatf("rggb_xy%0d", i), {rec.x, rec.y}, {12'(exp_x[i]), 12'(exp_y[i])});
      if (i == 0) check("rggb_phase0", rec.ph, 2'b11);
    end
    check("rggb_done_align", rec.cyc, 32'(done_cyc));
    check("rggb_latency", rec.cyc - 32'(last_cyc), 2);
    check("rggb_count", bus0.out_count, 9);
    check("rggb_done_cnt", done_cnt, 1);

    // in_done while IDLE is ignored, and the count holds.
    done_pulse();
    idle(4);
    check("idle_done_ignored", done_cnt, 1);
    check("count_hold", bus0.out_count, 9);

    // BGGR: red and blue swap.
    bus0.pattern = 2'b11;
    q0.delete();
    ramp(4, 1'b1);
    idle(4);
    check("bggr_n_out", q0.size(), 9);
    for (int i = 0; i < 9; i++) begin
      rec = pop0();
      check($sformatf("bggr_rgb%0d", i), {rec.r, rec.g, rec.b},
            {8'(exp_b[i]), 8'(exp_g[i]), 8'(exp_r[i])});
      if (i == 0) check("bggr_phase0", rec.ph, 2'b00);
    end

    // Quad (decimate) mode.
    bus0.pattern  = 2'b00;
    bus0.decimate = 1'b1;
    q0.delete();
    ramp(4, 1'b1);
    idle(4);
    check("dec_n_out", q0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      rec = pop0();
      check($sformatf("dec_rgb%0d", i), {rec.r, rec.g, rec.b},
            {8'(exp_r[dec_i[i]]), 8'(exp_g[dec_i[i]]), 8'(exp_b[dec_i[i]])});
      check($sformatf("dec_xy%0d", i), {rec.x, rec.y}, {12'(dec_x[i]), 12'(dec_y[i])});
    end
    check("dec_count", bus0.out_count, 4);

    // Green averaging at full scale, truncating vs rounding.
    bus0.decimate = 1'b0;
    bus0.width    = 12'd2;
    q0.delete();
    q1.delete();
    px(0, 0, 0, 0); px(1, 0, 255, 0); px(0, 1, 255, 0); px(1, 1, 0, 1);
    idle(4);
    rec = pop0();
    check("g255_r0", rec.g, 255);
    rec = pop1();
    check("g255_r1", rec.g, 255);
    px(0, 0, 0, 0); px(1, 0, 254, 0); px(0, 1, 255, 0); px(1, 1, 0, 1);
    idle(4);
    rec = pop0();
    check("g254_r0", rec.g, 254);
    rec = pop1();
    check("g254_r1", rec.g, 255);

    // Out-of-bounds pixel sets the sticky error, and the next frame start clears it.
    bus0.width = 12'd4;
    px(0, 0, 1, 0); px(1, 0, 2, 0); px(4, 0, 3, 0);
    idle(2);
    check("oob_error_set", bus0.out_error, 1);
    px(0, 0, 1, 0);
    idle(2);
    check("oob_error_clr", bus0.out_error, 0);
    done_pulse();
    idle(3);

    // Reset mid-frame suppresses output until the next frame start.
    ramp(3, 1'b0);
    idle(3);
    do_reset(2);
    check("midrst_count", bus0.out_count, 0);
    q0.delete();
    for (int x = 0; x < 4; x++) px(x, 3, 12 + x, 0);
    idle(4);
    check("midrst_no_out", q0.size(), 0);
    ramp(4, 1'b1);
    idle(4);
    check("midrst_resume_n", q0.size(), 9);
    check("midrst_resume_cnt", bus0.out_count, 9);

    // A frame start while ACTIVE restarts the frame and emits no out_done.
    base_done = done_cnt;
    ramp(2, 1'b0);
    ramp(4, 1'b1);
    idle(4);
    check("restart_count", bus0.out_count, 9);
    check("restart_done_cnt", done_cnt, base_done + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
